// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: fully pipelined tree summing 2**LEVELS operands, one register stage per level.
// Optional frame accumulator (acc_valid/acc_sum) is built only when ADDER_TREE_ACCUM_EN is defined.
module adder_tree_pipe #(
    parameter int ADDER_WIDTH = 13,
    parameter int LEVELS      = 3,
    parameter int SIGNED      = 0,
    parameter int ACC_LEN     = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic                                          in_valid,
    input  logic [(ADDER_WIDTH << LEVELS)-1:0]            in_data,
    output logic                                          out_valid,
    output logic [ADDER_WIDTH+LEVELS-1:0]                 sum
`ifdef ADDER_TREE_ACCUM_EN
    ,
    output logic                                          acc_valid,
    output logic [ADDER_WIDTH+LEVELS+$clog2(ACC_LEN)-1:0] acc_sum
`endif
);

    localparam int N     = 1 << LEVELS;
    localparam int SUM_W = ADDER_WIDTH + LEVELS;

    if (LEVELS < 1 || LEVELS > 6) begin : g_bad_levels
        $error("adder_tree_pipe: LEVELS must be in 1..6");
    end
    if (ACC_LEN < 2 || ACC_LEN > 256) begin : g_bad_acc_len
        $error("adder_tree_pipe: ACC_LEN must be in 2..256");
    end

    // Stage l holds N>>l values of ADDER_WIDTH+l bits; stage 0 is the input register.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_stage
        localparam int SW = ADDER_WIDTH + l;
        localparam int SN = N >> l;

        logic [SN*SW-1:0] data;
        logic             valid;

        if (l == 0) begin : g_input
            // NOTE: state registers use non-blocking assignments so every stage samples
            // the pre-edge value of its predecessor; data registers are reset as well,
            // so sum reads 0 after reset rather than stale contents.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data  <= '0;
                    valid <= 1'b0;
                end else if (en) begin
                    data  <= in_data;
                    valid <= in_valid;
                end
            end
        end else begin : g_level
            logic [SN*SW-1:0] pair_sum;

            for (genvar k = 0; k < SN; k++) begin : g_pair
                logic [SW-2:0] lo;
                logic [SW-2:0] hi;
                logic [SW-1:0] lo_ext;
                logic [SW-1:0] hi_ext;

                assign lo = g_stage[l-1].data[(2*k)*(SW-1) +: SW-1];
                assign hi = g_stage[l-1].data[(2*k+1)*(SW-1) +: SW-1];

                // One extra bit per level keeps the pairwise add exact.
                if (SIGNED != 0) begin : g_sext
                    assign lo_ext = {lo[SW-2], lo};
                    assign hi_ext = {hi[SW-2], hi};
                end else begin : g_zext
                    assign lo_ext = {1'b0, lo};
                    assign hi_ext = {1'b0, hi};
                end

                assign pair_sum[k*SW +: SW] = lo_ext + hi_ext;
            end

            // Data loads on every advancing cycle regardless of valid; valid qualifies it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data  <= '0;
                    valid <= 1'b0;
                end else if (en) begin
                    data  <= pair_sum;
                    valid <= g_stage[l-1].valid;
                end
            end
        end
    end

    assign sum       = g_stage[LEVELS].data;
    assign out_valid = g_stage[LEVELS].valid;

`ifdef ADDER_TREE_ACCUM_EN
    localparam int               CNT_W = $clog2(ACC_LEN);
    localparam int               ACC_W = SUM_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACC_LEN - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_next;
    logic             take;
    logic             wrap;

    assign sum_ext  = (SIGNED != 0) ? {{CNT_W{sum[SUM_W-1]}}, sum} : {{CNT_W{1'b0}}, sum};
    assign take     = en & out_valid;
    assign wrap     = take & (frame_cnt == LAST);
    assign acc_next = acc + sum_ext;

    // The closing sample goes straight into acc_sum and the accumulator restarts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            acc       <= '0;
            acc_sum   <= '0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= wrap;
            if (take) begin
                if (frame_cnt == LAST) begin
                    acc_sum   <= acc_next;
                    acc       <= '0;
                    frame_cnt <= '0;
                end else begin
                    acc       <= acc_next;
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed scenarios plus a random stream on
// four builds (LEVELS=3 unsigned/signed, LEVELS=1, LEVELS=6) against a delay-line model.
module tb_adder_tree_pipe;

    localparam int W = 13;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic vin;
    logic [103:0] d3;
    logic [103:0] ds;
    logic [25:0]  d1;
    logic [831:0] d6;

    logic ov3, ovs, ov1, ov6;
    logic [15:0] s3;
    logic [15:0] ss;
    logic [13:0] s1;
    logic [18:0] s6;
`ifdef ADDER_TREE_ACCUM_EN
    logic av3, avs, av1, av6;
    logic [17:0] as3;
    logic [17:0] ass;
    logic [15:0] as1;
    logic [20:0] as6;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.ADDER_WIDTH(W), .LEVELS(3), .SIGNED(0), .ACC_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vin), .in_data(d3),
        .out_valid(ov3), .sum(s3)
`ifdef ADDER_TREE_ACCUM_EN
        , .acc_valid(av3), .acc_sum(as3)
`endif
    );

    adder_tree_pipe #(.ADDER_WIDTH(W), .LEVELS(3), .SIGNED(1), .ACC_LEN(4)) u_signed (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vin), .in_data(ds),
        .out_valid(ovs), .sum(ss)
`ifdef ADDER_TREE_ACCUM_EN
        , .acc_valid(avs), .acc_sum(ass)
`endif
    );

    adder_tree_pipe #(.ADDER_WIDTH(W), .LEVELS(1), .SIGNED(0), .ACC_LEN(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vin), .in_data(d1),
        .out_valid(ov1), .sum(s1)
`ifdef ADDER_TREE_ACCUM_EN
        , .acc_valid(av1), .acc_sum(as1)
`endif
    );

    adder_tree_pipe #(.ADDER_WIDTH(W), .LEVELS(6), .SIGNED(0), .ACC_LEN(4)) u_l6 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(vin), .in_data(d6),
        .out_valid(ov6), .sum(s6)
`ifdef ADDER_TREE_ACCUM_EN
        , .acc_valid(av6), .acc_sum(as6)
`endif
    );

    // Reference model: each build is a delay line of LEVELS+1 advancing cycles carrying
    // (valid, arithmetic sum of the operands). Index 0 = newest, lat-1 = what sum shows.
    int  lat  [4] = '{4, 4, 2, 7};
    int  nops [4] = '{8, 8, 2, 64};
    int  sw   [4] = '{16, 16, 14, 19};
    bit  sgn  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit     mv [4][8];
    longint ms [4][8];

    logic        ov [4];
    logic [63:0] os [4];

    always_comb begin
        ov[0] = ov3;
        ov[1] = ovs;
        ov[2] = ov1;
        ov[3] = ov6;
        os[0] = 64'(s3);
        os[1] = 64'(ss);
        os[2] = 64'(s1);
        os[3] = 64'(s6);
    end

    function automatic longint ref_sum(input logic [831:0] d, input int n, input bit s);
        longint total;
        longint op;
        total = 0;
        for (int k = 0; k < n; k++) begin
            op = longint'(d >> (k * W)) & 64'h1FFF;
            if (s && op >= 4096) op = op - 8192;
            total = total + op;
        end
        return total;
    endfunction

    function automatic bit exp_valid(input int i);
        return mv[i][lat[i]-1];
    endfunction

    function automatic logic [63:0] exp_sum(input int i);
        return 64'(ms[i][lat[i]-1]) & ((64'd1 << sw[i]) - 64'd1);
    endfunction

    // One rising edge: the model consumes the same inputs the DUTs sample, then we
    // move to the falling edge where outputs are observed and new inputs are driven.
    task automatic tick();
        logic [831:0] dd [4];
        @(posedge clk);
        dd[0] = 832'(d3);
        dd[1] = 832'(ds);
        dd[2] = 832'(d1);
        dd[3] = d6;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                for (int j = 0; j < 8; j++) begin
                    mv[i][j] = 1'b0;
                    ms[i][j] = 0;
                end
            end else if (en) begin
                for (int j = lat[i] - 1; j > 0; j--) begin
                    mv[i][j] = mv[i][j-1];
                    ms[i][j] = ms[i][j-1];
                end
                mv[i][0] = vin;
                ms[i][0] = ref_sum(dd[i], nops[i], sgn[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        vin = 1'b0;
        d3  = '0;
        ds  = '0;
        d1  = '0;
        d6  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        vin   = 1'b1;
        d3    = '1;
        ds    = '1;
        d1    = '1;
        d6    = '1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid inst=%0d got=%b exp=0", i, ov[i]);
            end
            checks++;
            if (os[i] !== 64'd0) begin
                errors++;
                $display("FAIL reset_sum inst=%0d got=%0h exp=0", i, os[i]);
            end
        end
        rst_n = 1'b1;
        en    = 1'b1;
        clear_inputs();
    endtask

    task automatic test_max();
        d3  = {8{13'd8191}};
        vin = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                vin = 1'b0;
                d3  = '0;
            end
            checks++;
            if (ov3 !== (k == 4)) begin
                errors++;
                $display("FAIL max_valid k=%0d got=%b exp=%b", k, ov3, (k == 4));
            end
            if (k == 4) begin
                checks++;
                if (s3 !== 16'd65528) begin
                    errors++;
                    $display("FAIL max_sum got=%0d exp=65528", s3);
                end
            end
        end
    endtask

    task automatic test_signed();
        ds  = {8{13'h1000}};
        vin = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) ds = {4{13'h1000, 13'h0FFF}};
            if (k == 2) begin
                vin = 1'b0;
                ds  = '0;
            end
            checks++;
            if (ovs !== (k == 4 || k == 5)) begin
                errors++;
                $display("FAIL signed_valid k=%0d got=%b exp=%b", k, ovs, (k == 4 || k == 5));
            end
            if (k == 4) begin
                checks++;
                if (ss !== 16'h8000) begin
                    errors++;
                    $display("FAIL signed_min got=%0h exp=8000", ss);
                end
            end
            if (k == 5) begin
                checks++;
                if (ss !== 16'hFFFC) begin
                    errors++;
                    $display("FAIL signed_alt got=%0h exp=fffc", ss);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ev [9];
        int es [9];
        ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        es = '{0, 0, 0, 8, 8, 8, 100, 65528, 0};
        for (int k = 1; k <= 9; k++) begin
            case (k)
                1: begin d3 = 104'd8; vin = 1'b1; end
                2: d3 = 104'd100;
                3: d3 = {8{13'd8191}};
                4: begin vin = 1'b0; d3 = '0; end
                5: en = 1'b0;
                7: en = 1'b1;
                default: ;
            endcase
            tick();
            checks++;
            if (ov3 !== ev[k-1]) begin
                errors++;
                $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, ov3, ev[k-1]);
            end
            if (ev[k-1]) begin
                checks++;
                if (s3 !== 16'(es[k-1])) begin
                    errors++;
                    $display("FAIL b2b_sum k=%0d got=%0d exp=%0d", k, s3, es[k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 1; k <= 13; k++) begin
            case (k)
                1:  begin d3 = 104'd55; vin = 1'b1; end
                2:  d3 = 104'd77;
                3:  begin rst_n = 1'b0; vin = 1'b0; d3 = '0; end
                4:  rst_n = 1'b1;
                9:  begin d3 = 104'd9; vin = 1'b1; end
                10: begin vin = 1'b0; d3 = '0; end
                default: ;
            endcase
            tick();
            checks++;
            if (ov3 !== (k == 12)) begin
                errors++;
                $display("FAIL rstmid_valid k=%0d got=%b exp=%b", k, ov3, (k == 12));
            end
            checks++;
            if (s3 !== ((k == 12) ? 16'd9 : 16'd0)) begin
                errors++;
                $display("FAIL rstmid_sum k=%0d got=%0d exp=%0d", k, s3, (k == 12) ? 9 : 0);
            end
        end
    endtask

`ifdef ADDER_TREE_ACCUM_EN
    task automatic test_accum();
        int vals [8];
        vals  = '{10, 20, 30, 40, 5, 1, 1, 1};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (av3 !== 1'b0 || as3 !== 18'd0) begin
            errors++;
            $display("FAIL acc_reset got valid=%b sum=%0d exp valid=0 sum=0", av3, as3);
        end
        for (int k = 1; k <= 13; k++) begin
            if (k <= 8) begin
                d3  = 104'(vals[k-1]);
                vin = 1'b1;
            end else begin
                d3  = '0;
                vin = 1'b0;
            end
            tick();
            checks++;
            if (av3 !== (k == 8 || k == 12)) begin
                errors++;
                $display("FAIL acc_valid k=%0d got=%b exp=%b", k, av3, (k == 8 || k == 12));
            end
            if (k >= 8) begin
                checks++;
                if (as3 !== ((k >= 12) ? 18'd8 : 18'd100)) begin
                    errors++;
                    $display("FAIL acc_sum k=%0d got=%0d exp=%0d", k, as3, (k >= 12) ? 8 : 100);
                end
            end
        end
        clear_inputs();
    endtask
`endif

    task automatic test_random();
        logic [127:0] r;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 9) < 8);
            vin   = 1'($urandom_range(0, 1));
            r     = {$urandom(), $urandom(), $urandom(), $urandom()};
            d3    = r[103:0];
            r     = {$urandom(), $urandom(), $urandom(), $urandom()};
            ds    = r[103:0];
            d1    = r[127:102];
            for (int j = 0; j < 26; j++) d6[j*32 +: 32] = $urandom();
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ov[i] !== exp_valid(i)) begin
                    errors++;
                    $display("FAIL rand_valid inst=%0d cyc=%0d got=%b exp=%b", i, c, ov[i], exp_valid(i));
                end
                checks++;
                if (os[i] !== exp_sum(i)) begin
                    errors++;
                    $display("FAIL rand_sum inst=%0d cyc=%0d got=%0h exp=%0h", i, c, os[i], exp_sum(i));
                end
            end
        end
        rst_n = 1'b1;
        en    = 1'b1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_max();
        test_signed();
        test_back_to_back();
        test_reset_midflight();
`ifdef ADDER_TREE_ACCUM_EN
        test_accum();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
